// File: rtl/aes_decipher_iter_if.sv
// Ciphertext-in / plaintext-out bus of aes_decipher_iter.
//   in_valid/in_ready/in_text/in_key : ciphertext + key handshake (source -> block)
//   out_valid/out_ready/out_text     : plaintext handshake (block -> sink)
//   busy                             : block is computing (INIT/ROUND/FINAL)
// Text and key vectors use AES state order: bit 0 is the MSB of byte 0.
// modport master: the source/sink side; modport slave: the cipher block.
interface aes_decipher_iter_if #(
  parameter int NK = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [0:127]    in_text;
  logic [0:32*NK-1] in_key;
  logic            out_valid;
  logic            out_ready;
  logic [0:127]    out_text;
  logic            busy;

  modport master (
    output in_valid, in_text, in_key, out_ready,
    input  in_ready, out_valid, out_text, busy
  );

  modport slave (
    input  in_valid, in_text, in_key, out_ready,
    output in_ready, out_valid, out_text, busy
  );
endinterface

// File: rtl/aes_decipher_iter.sv
// Iterative AES inverse cipher (AES-128/192/256 chosen by Nk), one inverse
// round per clock on a single shared round datapath. The full key schedule is
// expanded combinationally from a registered copy of the key.
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   bus         aes_decipher_iter_if.slave (ciphertext/key in, plaintext out, busy)
//   o_dbg_state current FSM state, for checkers
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; in_text/in_key are captured on
// that edge only. out_valid is high only in DONE and out_text is stable there;
// the block leaves DONE on the edge where out_ready is high. valid never
// depends combinationally on ready.
module aes_decipher_iter #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_decipher_iter_if.slave bus,
  output logic [2:0]         o_dbg_state
);

  generate
    if (!(Nk == 4 || Nk == 6 || Nk == 8) || Nr != Nk + 6) begin : g_bad_param
      $error("aes_decipher_iter: Nk must be 4, 6 or 8 and Nr must equal Nk+6");
    end
  endgenerate

  localparam int NW = 4 * (Nr + 1);
  localparam int KW = 128 * (Nr + 1);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // ---------------------------------------------------------------- GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (9, 11, 13, 14 are all InvMixColumns needs).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Table byte 0 sits in the top bits of the flat constant.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[8*(255-int'(x)) +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[8*(255-int'(x)) +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // ---------------------------------------------------------- key schedule
  // Returns w[0..NW-1] packed so round key r is bits [128*r +: 128].
  function automatic logic [0:KW-1] key_expand(input logic [0:32*Nk-1] key);
    logic [31:0]     w [NW];
    logic [31:0]     t;
    logic [7:0]      rc;
    logic [0:KW-1]   res;
    rc  = 8'h01;
    res = '0;
    for (int i = 0; i < NW; i++) begin
      if (i < Nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % Nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = xtime(rc);
        end else if (Nk > 6 && i % Nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-Nk] ^ t;
      end
      res[32*i +: 32] = w[i];
    end
    return res;
  endfunction

  // ------------------------------------------------------- round functions
  // State byte (row r, column c) is byte r+4c of the 128-bit vector.
  // InvShiftRows and InvSubBytes commute, so both are done in one pass.
  function automatic logic [0:127] inv_shift_sub(input logic [0:127] s);
    logic [0:127] res;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[8*(r+4*c) +: 8] = inv_sbox(s[8*(r+4*((c-r+4)%4)) +: 8]);
      end
    end
    return res;
  endfunction

  function automatic logic [0:127] inv_mix(input logic [0:127] s);
    logic [0:127] res;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      res[32*c +: 8]    = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
      res[32*c+8 +: 8]  = gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
      res[32*c+16 +: 8] = gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
      res[32*c+24 +: 8] = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14);
    end
    return res;
  endfunction

  // ------------------------------------------------------------- datapath
  state_t            r_state;
  state_t            w_state_next;
  logic [0:127]      r_data;
  logic [0:127]      r_out;
  logic [0:32*Nk-1]  r_key;
  logic [3:0]        r_round;
  logic [3:0]        w_rk_idx;
  logic [0:KW-1]     w_keys;
  logic [0:127]      w_rk;
  logic [0:127]      w_sub;
  logic [0:127]      w_ark;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_busy;

  assign w_keys = key_expand(r_key);

  // Round keys are consumed last-to-first: rk[Nr] in INIT, rk[Nr-round] in
  // ROUND, rk[0] in FINAL. round stays in 1..Nr-1, so the index never wraps.
  always_comb begin
    w_rk_idx = 4'(Nr) - r_round;
    case (r_state)
      S_INIT:  w_rk_idx = 4'(Nr);
      S_FINAL: w_rk_idx = 4'd0;
      default: w_rk_idx = 4'(Nr) - r_round;
    endcase
  end

  assign w_rk  = w_keys[128*int'(w_rk_idx) +: 128];
  assign w_sub = inv_shift_sub(r_data);
  assign w_ark = w_sub ^ w_rk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_key   <= '0;
      r_out   <= '0;
      r_round <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_key  <= bus.in_key;
            r_data <= bus.in_text;
          end
        end
        S_INIT: begin
          r_data  <= r_data ^ w_rk;
          r_round <= 4'd1;
        end
        S_ROUND: begin
          r_data <= inv_mix(w_ark);
          if (r_round != 4'(Nr - 1)) r_round <= r_round + 4'd1;
        end
        S_FINAL: r_out <= w_ark;
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_next = S_INIT;
      end
      S_INIT: begin
        w_busy       = 1'b1;
        w_state_next = S_ROUND;
      end
      S_ROUND: begin
        w_busy = 1'b1;
        if (r_round == 4'(Nr - 1)) w_state_next = S_FINAL;
      end
      S_FINAL: begin
        w_busy       = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.out_text  = r_out;
  assign o_dbg_state   = r_state;

endmodule
